// File: rtl/rps_pkg.sv
// rps_pkg: result codes, winner encodings and FSM states shared by the judge and the match scorer.
package rps_pkg;
    localparam logic [7:0] RES_TIE = 8'd0;
    localparam logic [7:0] RES_P1  = 8'd49;
    localparam logic [7:0] RES_P2  = 8'd50;
    localparam logic [7:0] RES_INV = 8'd63;
    typedef enum logic [1:0] {W_NONE = 2'b00, W_P1 = 2'b01, W_P2 = 2'b10, W_DRAW = 2'b11} winner_t;
    typedef enum logic {S_PLAY = 1'b0, S_DONE = 1'b1} state_t;
endpackage

// File: rtl/rps_sat_counter.sv
// rps_sat_counter: W-bit counter with sync clear, increment enable and saturation at MAX.
// o_q_nxt exposes the post-update value so callers can decide on it in the same edge.
module rps_sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_q_nxt
);
    logic [W-1:0] r_q;
    always_comb o_q_nxt = i_clr ? '0 : (i_inc && r_q != W'(MAX)) ? r_q + 1'b1 : r_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_q <= '0;
        else        r_q <= o_q_nxt;
    assign o_q = r_q;
endmodule

// File: rtl/rps_match_scorer.sv
// rps_match_scorer: best-of-N match scorekeeper fed by the round judge's result code.
// Scores, round and invalid counts update on each accepted strobe; the result holds in DONE.
module rps_match_scorer
    import rps_pkg::*;
#(
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] result,
    input  logic       round_strobe,
    input  logic       new_match,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [4:0] round_cnt,
    output logic [3:0] invalid_cnt,
    output logic       match_over,
    output logic [1:0] match_winner,
    output logic       round_done,
    output logic       match_over_pulse
);
    state_t  r_state, w_state_nxt;
    winner_t r_winner, w_winner_nxt;
    logic r_round_done, r_over_pulse;
    logic w_clr, w_acc, w_is_p1, w_is_p2, w_is_tie, w_inv;
    logic w_p1_win, w_p2_win, w_lim, w_fin;
    logic [3:0] w_p1_n, w_p2_n, w_inv_n;
    logic [4:0] w_rnd_n;
    // new_match outranks a coincident strobe, which is simply dropped
    assign w_clr    = ena & new_match;
    assign w_acc    = ena & round_strobe & ~new_match & (r_state == S_PLAY);
    assign w_is_p1  = result == RES_P1;
    assign w_is_p2  = result == RES_P2;
    assign w_is_tie = result == RES_TIE;
    assign w_inv    = ~(w_is_p1 | w_is_p2 | w_is_tie);
    rps_sat_counter #(.W(4), .MAX(WIN_TARGET)) u_p1 (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_inc(w_acc & w_is_p1), .o_q(p1_score), .o_q_nxt(w_p1_n));
    rps_sat_counter #(.W(4), .MAX(WIN_TARGET)) u_p2 (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_inc(w_acc & w_is_p2), .o_q(p2_score), .o_q_nxt(w_p2_n));
    rps_sat_counter #(.W(5), .MAX(MAX_ROUNDS)) u_rnd (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_inc(w_acc & ~w_inv), .o_q(round_cnt), .o_q_nxt(w_rnd_n));
    rps_sat_counter #(.W(4), .MAX(15)) u_inv (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_inc(w_acc & w_inv), .o_q(invalid_cnt), .o_q_nxt(w_inv_n));
    // finish decision is taken on the post-update counts
    assign w_p1_win = w_p1_n == 4'(WIN_TARGET);
    assign w_p2_win = w_p2_n == 4'(WIN_TARGET);
    assign w_lim    = w_rnd_n == 5'(MAX_ROUNDS);
    assign w_fin    = w_acc & (w_p1_win | w_p2_win | w_lim);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= S_PLAY;
        else        r_state <= w_state_nxt;
    always_comb w_state_nxt = w_clr ? S_PLAY : w_fin ? S_DONE : r_state;
    always_comb
        w_winner_nxt = w_clr           ? W_NONE :
                       !w_fin          ? r_winner :
                       w_p1_win        ? W_P1 :
                       w_p2_win        ? W_P2 :
                       w_p1_n > w_p2_n ? W_P1 :
                       w_p2_n > w_p1_n ? W_P2 : W_DRAW;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_winner     <= W_NONE;
            r_round_done <= 1'b0;
            r_over_pulse <= 1'b0;
        end else begin
            r_winner     <= w_winner_nxt;
            r_round_done <= w_acc;
            r_over_pulse <= w_fin;
        end
    assign match_over       = r_state == S_DONE;
    assign match_winner     = r_winner;
    assign round_done       = r_round_done;
    assign match_over_pulse = r_over_pulse;
endmodule

// File: tb/tb_rps_match_scorer.sv
// tb_rps_match_scorer: directed vectors against a rule-level match model, checked every cycle.
`timescale 1ns/1ps
module tb_rps_match_scorer;
    localparam int WT = 3;
    localparam int MR = 9;
    logic clk = 1'b0;
    logic rst_n, ena, round_strobe, new_match;
    logic [7:0] result;
    logic [3:0] p1_score, p2_score, invalid_cnt;
    logic [4:0] round_cnt;
    logic match_over, round_done, match_over_pulse;
    logic [1:0] match_winner;
    int checks = 0;
    int errors = 0;

    rps_match_scorer #(.WIN_TARGET(WT), .MAX_ROUNDS(MR)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .result(result), .round_strobe(round_strobe),
        .new_match(new_match), .p1_score(p1_score), .p2_score(p2_score), .round_cnt(round_cnt),
        .invalid_cnt(invalid_cnt), .match_over(match_over), .match_winner(match_winner),
        .round_done(round_done), .match_over_pulse(match_over_pulse));

    always #5 clk = ~clk;

    typedef struct {
        int p1, p2, rnd, inv, win;
        bit over, rd, mop;
    } mstate_t;
    mstate_t m;

    // One edge of the match rules applied to the whole scoreboard.
    function automatic mstate_t step(mstate_t s, bit en, bit st, bit nm, logic [7:0] code);
        mstate_t n = s;
        n.rd = 0;
        n.mop = 0;
        if (!en) return n;
        if (nm) begin
            n.p1 = 0; n.p2 = 0; n.rnd = 0; n.inv = 0; n.win = 0; n.over = 0;
            return n;
        end
        if (!st || s.over) return n;
        n.rd = 1;
        if (code == 8'd49) begin n.p1++; n.rnd++; end
        else if (code == 8'd50) begin n.p2++; n.rnd++; end
        else if (code == 8'd0) n.rnd++;
        else if (n.inv < 15) n.inv++;
        if (n.p1 == WT) begin n.win = 1; n.over = 1; n.mop = 1; end
        else if (n.p2 == WT) begin n.win = 2; n.over = 1; n.mop = 1; end
        else if (n.rnd == MR) begin
            n.over = 1; n.mop = 1;
            n.win = (n.p1 > n.p2) ? 1 : (n.p2 > n.p1) ? 2 : 3;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= '{default: 0};
        else        m <= step(m, ena, round_strobe, new_match, result);

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("p1_score", int'(p1_score), m.p1);
        chk("p2_score", int'(p2_score), m.p2);
        chk("round_cnt", int'(round_cnt), m.rnd);
        chk("invalid_cnt", int'(invalid_cnt), m.inv);
        chk("match_winner", int'(match_winner), m.win);
        chk("match_over", int'(match_over), int'(m.over));
        chk("round_done", int'(round_done), int'(m.rd));
        chk("match_over_pulse", int'(match_over_pulse), int'(m.mop));
    end

    task automatic cyc(input bit s, input logic [7:0] r, input bit n, input bit e);
        round_strobe = s;
        result = r;
        new_match = n;
        ena = e;
        @(posedge clk);
        #1;
        round_strobe = 0;
        new_match = 0;
        ena = 1;
    endtask

    initial begin
        logic [7:0] draw_seq [9] = '{8'd49, 8'd50, 8'd0, 8'd49, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0};
        rst_n = 0; ena = 1; round_strobe = 0; new_match = 0; result = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset p1", int'(p1_score), 0);
        chk("reset over", int'(match_over), 0);
        chk("reset winner", int'(match_winner), 0);
        rst_n = 1;
        // straight P1 win
        repeat (3) cyc(1, 8'd49, 0, 1);
        chk("p1win score", int'(p1_score), 3);
        chk("p1win rounds", int'(round_cnt), 3);
        chk("p1win winner", int'(match_winner), 1);
        chk("p1win over", int'(match_over), 1);
        chk("p1win pulse", int'(match_over_pulse), 1);
        chk("p1win rd", int'(round_done), 1);
        cyc(0, 8'd0, 0, 1);
        chk("pulse one cycle", int'(match_over_pulse), 0);
        cyc(1, 8'd49, 0, 1);
        chk("done no rd", int'(round_done), 0);
        chk("done hold p1", int'(p1_score), 3);
        // draw at round limit
        cyc(0, 8'd0, 1, 1);
        chk("new match over", int'(match_over), 0);
        for (int i = 0; i < 9; i++) cyc(1, draw_seq[i], 0, 1);
        chk("draw p1", int'(p1_score), 2);
        chk("draw p2", int'(p2_score), 2);
        chk("draw rounds", int'(round_cnt), 9);
        chk("draw winner", int'(match_winner), 3);
        chk("draw over", int'(match_over), 1);
        // invalid codes
        cyc(0, 8'd0, 1, 1);
        cyc(1, 8'd63, 0, 1);
        chk("inv rd 1", int'(round_done), 1);
        cyc(1, 8'd7, 0, 1);
        chk("inv rd 2", int'(round_done), 1);
        cyc(1, 8'd49, 0, 1);
        chk("inv rd 3", int'(round_done), 1);
        chk("inv count", int'(invalid_cnt), 2);
        chk("inv rounds", int'(round_cnt), 1);
        chk("inv p1", int'(p1_score), 1);
        repeat (20) cyc(1, 8'd63, 0, 1);
        chk("inv saturate", int'(invalid_cnt), 15);
        // new_match colliding with a strobe
        cyc(0, 8'd0, 1, 1);
        repeat (2) cyc(1, 8'd50, 0, 1);
        chk("coll pre p2", int'(p2_score), 2);
        cyc(1, 8'd50, 1, 1);
        chk("coll p2", int'(p2_score), 0);
        chk("coll rounds", int'(round_cnt), 0);
        chk("coll winner", int'(match_winner), 0);
        chk("coll over", int'(match_over), 0);
        chk("coll rd", int'(round_done), 0);
        // ena gating
        cyc(1, 8'd50, 0, 1);
        cyc(1, 8'd49, 0, 1);
        cyc(1, 8'd49, 0, 0);
        chk("gate rd", int'(round_done), 0);
        chk("gate p1", int'(p1_score), 1);
        cyc(0, 8'd0, 1, 0);
        chk("gate nm p2", int'(p2_score), 1);
        chk("gate nm rounds", int'(round_cnt), 2);
        cyc(1, 8'd50, 0, 1);
        chk("resume p2", int'(p2_score), 2);
        chk("resume rounds", int'(round_cnt), 3);
        // asynchronous reset between edges
        #2;
        rst_n = 0;
        #1;
        chk("areset p1", int'(p1_score), 0);
        chk("areset p2", int'(p2_score), 0);
        chk("areset rounds", int'(round_cnt), 0);
        chk("areset rd", int'(round_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        cyc(1, 8'd50, 0, 1);
        chk("post reset p2", int'(p2_score), 1);
        cyc(0, 8'd0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
